// File: rtl/kiwi_chan_accum.sv
// kiwi_chan_accum -- multi-channel streaming accumulator.
//
// Tagged input beats are summed into per-channel accumulators. A burst closes
// on in_last or when MAX_BEATS beats have been taken on a channel. Each closed
// burst is emitted as one result through a single valid/ready output register.
// A flush sweep walks every channel once and drains any partial sums, which
// lets the producer end a run cleanly.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_valid / in_ready / in_chan / in_data / in_last   beat input
//   flush_req  start a drain of all non-empty channels
//   flush_done one-cycle pulse when the sweep completes
//   out_valid / out_ready / out_chan / out_sum / out_count / out_sat  result
//   err_chan   sticky; an out-of-range channel tag was accepted
//
// Optional build macro: KIWI_ACC_SAT_EN
//   defined   -> sums clamp at 2^ACC_W-1 and the result reports out_sat=1
//   undefined -> sums wrap modulo 2^ACC_W and out_sat is tied low
module kiwi_chan_accum #(
  parameter  int DATA_W    = 16,
  parameter  int ACC_W     = 24,
  parameter  int CHANNELS  = 4,
  parameter  int MAX_BEATS = 16,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_chan,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output logic              err_chan
);

  localparam logic [CH_W:0]    CH_LIM   = (CH_W+1)'(CHANNELS);
  localparam logic [CH_W-1:0]  LAST_IDX = CH_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] MAXB     = CNT_W'(MAX_BEATS);

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t                           r_state, w_state_nxt;
  logic [CHANNELS-1:0][ACC_W-1:0]   r_acc;
  logic [CHANNELS-1:0][CNT_W-1:0]   r_cnt;
  logic [CH_W-1:0]                  r_fidx;
  logic                             r_flush_done;
  logic                             r_err;
  logic                             r_out_valid;
  logic [CH_W-1:0]                  r_out_chan;
  logic [ACC_W-1:0]                 r_out_sum;
  logic [CNT_W-1:0]                 r_out_cnt;

  logic                             w_slot_free, w_flush_step;
  logic                             w_chan_ok, w_beat, w_close, w_emit_beat;
  logic [CH_W-1:0]                  w_ci;
  logic [ACC_W-1:0]                 w_acc_sel, w_nsum, w_facc;
  logic [CNT_W-1:0]                 w_cnt_sel, w_ncnt, w_fcnt;
  logic                             w_flush_emit;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (flush_req) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_slot_free && r_fidx == LAST_IDX) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  assign w_slot_free = !r_out_valid || out_ready;
  always_comb begin
    in_ready     = (r_state == S_RUN) && w_slot_free;
    // The sweep index only advances when a result could be loaded, so an
    // empty channel also waits out backpressure; this keeps the cost simple.
    w_flush_step = (r_state == S_FLUSH) && w_slot_free;
  end

  // ---------------- beat datapath ----------------
  assign w_chan_ok = ({1'b0, in_chan} < CH_LIM);
  // Out-of-range tags never touch state, but the read mux still needs a
  // legal index.
  assign w_ci      = w_chan_ok ? in_chan : '0;
  assign w_acc_sel = r_acc[w_ci];
  assign w_cnt_sel = r_cnt[w_ci];
  assign w_ncnt    = w_cnt_sel + CNT_W'(1);

`ifdef KIWI_ACC_SAT_EN
  logic [CHANNELS-1:0] r_sat;
  logic                r_out_sat;
  logic [ACC_W:0]      w_sum_ext;
  logic                w_nsat;
  assign w_sum_ext = {1'b0, w_acc_sel} + {1'b0, ACC_W'(in_data)};
  // Once a channel has clamped it stays clamped until the burst closes.
  assign w_nsat    = r_sat[w_ci] | w_sum_ext[ACC_W];
  assign w_nsum    = w_nsat ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  assign out_sat   = r_out_sat;
`else
  assign w_nsum    = w_acc_sel + ACC_W'(in_data);
  assign out_sat   = 1'b0;
`endif

  assign w_beat       = in_valid && in_ready && w_chan_ok;
  assign w_close      = in_last || (w_ncnt == MAXB);
  assign w_emit_beat  = w_beat && w_close;

  assign w_facc       = r_acc[r_fidx];
  assign w_fcnt       = r_cnt[r_fidx];
  assign w_flush_emit = w_flush_step && (w_fcnt != '0);

  // ---------------- per-channel accumulators ----------------
  // Beats and flush emits never coincide: in_ready is low during FLUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
`ifdef KIWI_ACC_SAT_EN
      r_sat <= '0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_beat && w_ci == CH_W'(i)) begin
          if (w_close) begin
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
`ifdef KIWI_ACC_SAT_EN
            r_sat[i] <= 1'b0;
`endif
          end else begin
            r_acc[i] <= w_nsum;
            r_cnt[i] <= w_ncnt;
`ifdef KIWI_ACC_SAT_EN
            r_sat[i] <= w_nsat;
`endif
          end
        end else if (w_flush_emit && r_fidx == CH_W'(i)) begin
          r_acc[i] <= '0;
          r_cnt[i] <= '0;
`ifdef KIWI_ACC_SAT_EN
          r_sat[i] <= 1'b0;
`endif
        end
      end
    end
  end

  // ---------------- flush sweep, error flag ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fidx       <= '0;
      r_flush_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_flush_done <= w_flush_step && (r_fidx == LAST_IDX);
      if (w_flush_step)
        r_fidx <= (r_fidx == LAST_IDX) ? '0 : r_fidx + CH_W'(1);
      if (in_valid && in_ready && !w_chan_ok)
        r_err <= 1'b1;
    end
  end

  // ---------------- output register ----------------
  // Loading is gated by slot_free, so a consumed result is replaced in the
  // same cycle and back-to-back results carry no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
`ifdef KIWI_ACC_SAT_EN
      r_out_sat   <= 1'b0;
`endif
    end else if (w_slot_free) begin
      if (w_emit_beat) begin
        r_out_valid <= 1'b1;
        r_out_chan  <= w_ci;
        r_out_sum   <= w_nsum;
        r_out_cnt   <= w_ncnt;
`ifdef KIWI_ACC_SAT_EN
        r_out_sat   <= w_nsat;
`endif
      end else if (w_flush_emit) begin
        r_out_valid <= 1'b1;
        r_out_chan  <= r_fidx;
        r_out_sum   <= w_facc;
        r_out_cnt   <= w_fcnt;
`ifdef KIWI_ACC_SAT_EN
        r_out_sat   <= r_sat[r_fidx];
`endif
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign flush_done = r_flush_done;
  assign err_chan   = r_err;
  assign out_valid  = r_out_valid;
  assign out_chan   = r_out_chan;
  assign out_sum    = r_out_sum;
  assign out_count  = r_out_cnt;

endmodule

// File: tb/tb_kiwi_chan_accum.sv
// Directed bench for kiwi_chan_accum. Instance A (ACC_W=18, 4 channels)
// covers accumulate, interleave, forced emit, backpressure and flush.
// Instance B (3 channels) covers the out-of-range tag and mid-burst reset.
module tb_kiwi_chan_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- instance A ----------------
  logic        a_rst, a_iv, a_ir, a_last, a_fr, a_fd, a_ov, a_or, a_sat, a_err;
  logic [1:0]  a_ch, a_och;
  logic [15:0] a_d;
  logic [17:0] a_sum;
  logic [4:0]  a_cnt;

  kiwi_chan_accum #(.DATA_W(16), .ACC_W(18), .CHANNELS(4), .MAX_BEATS(16)) u_a (
    .clk(clk), .reset(a_rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_chan(a_ch), .in_data(a_d), .in_last(a_last),
    .flush_req(a_fr), .flush_done(a_fd),
    .out_valid(a_ov), .out_ready(a_or), .out_chan(a_och), .out_sum(a_sum),
    .out_count(a_cnt), .out_sat(a_sat), .err_chan(a_err));

  // ---------------- instance B ----------------
  logic        b_rst, b_iv, b_ir, b_last, b_fr, b_fd, b_ov, b_or, b_sat, b_err;
  logic [1:0]  b_ch, b_och;
  logic [15:0] b_d;
  logic [23:0] b_sum;
  logic [4:0]  b_cnt;

  kiwi_chan_accum #(.DATA_W(16), .ACC_W(24), .CHANNELS(3), .MAX_BEATS(16)) u_b (
    .clk(clk), .reset(b_rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_chan(b_ch), .in_data(b_d), .in_last(b_last),
    .flush_req(b_fr), .flush_done(b_fd),
    .out_valid(b_ov), .out_ready(b_or), .out_chan(b_och), .out_sum(b_sum),
    .out_count(b_cnt), .out_sat(b_sat), .err_chan(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [1:0] ch, input logic [15:0] d, input logic last);
    a_iv = 1'b1; a_ch = ch; a_d = d; a_last = last;
    tick();
  endtask

  task automatic a_out(input string tag, input logic [1:0] ch, input logic [17:0] s,
                       input logic [4:0] c);
    chk({tag, ".valid"}, a_ov,  1);
    chk({tag, ".chan"},  a_och, ch);
    chk({tag, ".sum"},   a_sum, s);
    chk({tag, ".count"}, a_cnt, c);
  endtask

  initial begin
    a_rst = 0; a_iv = 0; a_ch = 0; a_d = 0; a_last = 0; a_fr = 0; a_or = 1;
    b_rst = 0; b_iv = 0; b_ch = 0; b_d = 0; b_last = 0; b_fr = 0; b_or = 1;
    tick(); tick();

    // reset state
    chk("rst.out_valid", a_ov, 0);
    chk("rst.out_sum",   a_sum, 0);
    chk("rst.out_count", a_cnt, 0);
    chk("rst.out_chan",  a_och, 0);
    chk("rst.flush_done", a_fd, 0);
    chk("rst.err_chan",  a_err, 0);
    a_rst = 1; b_rst = 1;
    tick();
    chk("run.in_ready", a_ir, 1);

    // T1: channel 2 burst 5+7+9
    a_beat(2, 5, 0);
    chk("t1.no_early_out", a_ov, 0);
    a_beat(2, 7, 0);
    a_beat(2, 9, 1);
    a_out("t1", 2, 21, 3);
    chk("t1.sat", a_sat, 0);
    a_iv = 0; a_last = 0;
    tick();
    chk("t1.consumed", a_ov, 0);

    // T2: interleaved ch0 / ch1
    a_beat(0, 1, 0);
    a_beat(1, 10, 0);
    a_beat(0, 2, 0);
    a_beat(0, 3, 1);
    a_out("t2.ch0", 0, 6, 3);
    a_beat(1, 20, 1);
    a_out("t2.ch1", 1, 30, 2);
    a_iv = 0; a_last = 0;
    tick();
    chk("t2.consumed", a_ov, 0);

    // T3: 16 x 0xFFFF on ch3, no last -> forced emit
    for (int i = 0; i < 15; i++) a_beat(3, 16'hFFFF, 0);
    chk("t3.no_emit_at_15", a_ov, 0);
    a_beat(3, 16'hFFFF, 0);
`ifdef KIWI_ACC_SAT_EN
    a_out("t3", 3, 18'h3FFFF, 16);
    chk("t3.sat", a_sat, 1);
`else
    a_out("t3", 3, 18'h3FFF0, 16);
    chk("t3.sat", a_sat, 0);
`endif
    a_iv = 0;
    tick();

    // T4: backpressure
    a_beat(1, 7, 1);
    a_out("t4.first", 1, 7, 1);
    a_or = 0; a_iv = 1; a_ch = 1; a_d = 3; a_last = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4.in_ready_low", a_ir, 0);
      a_out("t4.hold", 1, 7, 1);
    end
    a_or = 1;
    #1;
    chk("t4.in_ready_release", a_ir, 1);
    tick();
    a_out("t4.next", 1, 3, 1);
    a_iv = 0; a_last = 0;
    tick();
    chk("t4.consumed", a_ov, 0);

    // T5: flush of partial sums ch0=4 (1 beat), ch2=8 (2 beats)
    a_beat(0, 4, 0);
    a_beat(2, 3, 0);
    a_beat(2, 5, 0);
    a_iv = 0; a_fr = 1;
    tick();
    a_fr = 0;
    chk("t5.ready_i0", a_ir, 0);
    tick();
    a_out("t5.ch0", 0, 4, 1);
    chk("t5.ready_i1", a_ir, 0);
    chk("t5.done_i1", a_fd, 0);
    tick();
    chk("t5.empty_ch1", a_ov, 0);
    chk("t5.ready_i2", a_ir, 0);
    tick();
    a_out("t5.ch2", 2, 8, 2);
    chk("t5.ready_i3", a_ir, 0);
    chk("t5.done_i3", a_fd, 0);
    tick();
    chk("t5.flush_done", a_fd, 1);
    chk("t5.empty_ch3", a_ov, 0);
    chk("t5.back_to_run", a_ir, 1);
    tick();
    chk("t5.done_pulse", a_fd, 0);

    // T6: out-of-range channel, sticky error, mid-burst reset (instance B)
    b_iv = 1; b_ch = 3; b_d = 5; b_last = 1;
    tick();
    chk("t6.err_set", b_err, 1);
    chk("t6.dropped", b_ov, 0);
    b_ch = 1; b_d = 6; b_last = 1;
    tick();
    chk("t6.err_sticky", b_err, 1);
    chk("t6.sum6", b_sum, 6);
    b_d = 100; b_last = 0;
    tick();
    b_iv = 0;
    tick();
    b_rst = 0;
    #1;
    chk("t6.rst_valid", b_ov, 0);
    chk("t6.rst_sum", b_sum, 0);
    chk("t6.rst_count", b_cnt, 0);
    chk("t6.rst_err", b_err, 0);
    tick(); tick();
    b_rst = 1;
    tick();
    b_iv = 1; b_ch = 1; b_d = 9; b_last = 1;
    tick();
    chk("t6.fresh_valid", b_ov, 1);
    chk("t6.fresh_sum", b_sum, 9);
    chk("t6.fresh_count", b_cnt, 1);
    b_iv = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/kiwi_chan_accum.md
Name: kiwi_chan_accum

Overview:
- Parametrised, multi-channel streaming accumulator. It follows on from the single-thread KiwiC regression top-levels, which have clk/reset and no datapath.
- Sums tagged input beats into per-channel accumulators.
- Emits one result per burst, closed by in_last or MAX_BEATS, through a valid/ready output register.
- Sits between a Kiwi-generated producer thread and a result consumer. Provides a flush sweep for end-of-run drain.

Parameters:
- DATA_W, 16, input beat width (unsigned).
- ACC_W, 24, accumulator/result width; must be >= DATA_W.
- CHANNELS, 4, number of independent accumulators; 1..16.
- MAX_BEATS, 16, beats per channel before a forced emit; 2..256.
- CH_W = max(1, clog2(CHANNELS)), local parameter.
- CNT_W = clog2(MAX_BEATS+1), local parameter.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous active-low reset (asserted when 0).
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- in_chan, input, CH_W, channel tag.
- in_data, input, DATA_W, beat value.
- in_last, input, 1, closes the channel burst.
- flush_req, input, 1, request to drain all non-empty channels.
- flush_done, output, 1, one-cycle pulse at end of flush.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- out_chan, output, CH_W, channel of the result.
- out_sum, output, ACC_W, burst sum.
- out_count, output, CNT_W, beats in the burst (1..MAX_BEATS).
- out_sat, output, 1, result saturated (0 unless KIWI_ACC_SAT_EN).
- err_chan, output, 1, sticky flag: out-of-range channel seen.

Behaviour:
- Reset (reset=0, async): state=RUN, all acc/cnt=0, flush index=0. Outputs: out_valid=0, out_chan=0, out_sum=0, out_count=0, out_sat=0, flush_done=0, err_chan=0. Reset mid-burst or mid-flush discards all partial sums.
- slot_free = !out_valid || out_ready.
- in_ready = (state==RUN) && slot_free.
- States:
  - RUN: accepts beats. flush_req=1 → FLUSH next cycle.
  - FLUSH: in_ready=0; flush_req is ignored.
- Accepted beat on channel c (c < CHANNELS): nsum = acc[c] + zero-extended in_data, mod 2^ACC_W. ncnt = cnt[c]+1.
  - If in_last or ncnt==MAX_BEATS: load output regs (out_chan=c, out_sum=nsum, out_count=ncnt, out_valid=1) next cycle. Clear acc[c] and cnt[c].
  - Otherwise: acc[c]=nsum, cnt[c]=ncnt.
- Accepted beat with c >= CHANNELS: beat is dropped and err_chan is set. err_chan clears only on reset.
- Output register: holds while out_valid && !out_ready. Acceptance and a new load in the same cycle give back-to-back results with no bubble (latency 1 cycle, throughput 1/cycle).
- A beat and flush_req in the same cycle: the beat is accepted first and is included in the flush.
- FLUSH, per channel index i from 0 to CHANNELS-1:
  - Each cycle with slot_free: if cnt[i]!=0, emit acc[i]/cnt[i] for channel i and clear it. Then i++.
  - Empty channels take one cycle each with no emit.
  - Without slot_free, i stalls.
  - After i=CHANNELS-1 is processed: flush_done=1 for one cycle, i=0, state=RUN.
- Flush cost: CHANNELS cycles minimum, plus backpressure stalls.

Optional Feature:
- Macro: KIWI_ACC_SAT_EN.
- Defined: if the unsigned add carries out of ACC_W, the accumulator clamps to 2^ACC_W-1 and a per-channel sat bit is set. Further adds stay clamped. The result carries out_sat=1, and the sat bit clears with the accumulator.
- Undefined: the sum wraps modulo 2^ACC_W, out_sat is tied to 0, and no sat state is built.

Test Plan:
1. Defaults; channel 2 beats 5, 7, 9, last on the third → one cycle later out_valid=1, out_chan=2, out_sum=21, out_count=3.
2. Interleave channel 0 (1,2,last 3) and channel 1 (10,last 20), out_ready=1 → results ch0 sum 6 count 3, then ch1 sum 30 count 2; no cross-contamination.
3. ACC_W=18, 16 beats of 0xFFFF on channel 3 with no last → forced emit at beat 16, out_count=16. out_sum=0x3FFF0 without the macro; out_sum=0x3FFFF and out_sat=1 with KIWI_ACC_SAT_EN.
4. Hold out_ready=0 after one result, drive in_valid → in_ready=0 and outputs stable 5 cycles. Release → result accepted, next beat accepted the same cycle.
5. Partial ch0=4 (1 beat), ch2=8 (2 beats), then flush_req with out_ready=1 → emits (ch0,4,1), (ch2,8,2), flush_done one cycle after i=3, in_ready=0 throughout FLUSH.
6. CHANNELS=3, in_chan=3 → beat dropped, err_chan=1 sticky. Mid-burst reset=0 for 2 cycles → all outputs at reset values; next burst on that channel starts from 0.
